// File: rtl/lcl_burst_pkg.sv
// rtl/lcl_burst_pkg.sv - shared types and helpers for the local burst responder
package lcl_burst_pkg;

  localparam int BEAT_CNT_W = 9;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_WAIT = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // An 8-bit beat field of zero encodes the maximum burst of 256 beats.
  function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [7:0] num);
    return (num == 8'd0) ? 9'd256 : {1'b0, num};
  endfunction

endpackage

// File: rtl/lcl_burst_ram.sv
// rtl/lcl_burst_ram.sv - simple dual-port word RAM, registered read-first output
module lcl_burst_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [MEM_AW-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [MEM_AW-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<MEM_AW)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both ports use nonblocking updates, so a same-word read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcl_burst_responder.sv
// rtl/lcl_burst_responder.sv - target side of the local write/read burst interface
module lcl_burst_responder
  import lcl_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lcl_istart,
  input  logic [ADDR_WIDTH-1:0] lcl_iaddr,
  input  logic [7:0]            lcl_inum,
  output logic                  lcl_ibusy,
  output logic                  lcl_irdy,
  input  logic                  lcl_den,
  input  logic [DATA_WIDTH-1:0] lcl_din,
  input  logic                  lcl_idone,
  input  logic                  lcl_ostart,
  input  logic [ADDR_WIDTH-1:0] lcl_oaddr,
  input  logic [7:0]            lcl_onum,
  output logic                  lcl_obusy,
  output logic                  lcl_ordy,
  input  logic                  lcl_rden,
  output logic                  lcl_dv,
  output logic [DATA_WIDTH-1:0] lcl_dout,
  output logic                  lcl_odone,
  output logic                  proto_err
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam logic [MEM_AW-1:0] IDX_ONE = 1;

  w_state_e              w_state_q, w_state_d;
  logic [MEM_AW-1:0]     w_idx_q, w_idx_d;
  logic [BEAT_CNT_W-1:0] w_cnt_q, w_cnt_d, w_num_q, w_num_d, w_cnt_inc;
  logic                  w_err, ram_we;

  r_state_e              r_state_q, r_state_d;
  logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
  logic [BEAT_CNT_W-1:0] r_rem_q, r_rem_d;
  logic                  r_err, ram_re;
  logic                  dv_q, dv_d, odone_q, odone_d, err_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Only the word-index bits of the addresses matter; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lcl_iaddr, lcl_oaddr};

  assign w_cnt_inc = w_cnt_q + 9'd1;

  // Write channel next state: accept beats until the burst count, then wait for idone.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_num_d   = w_num_q;
    w_err     = 1'b0;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (lcl_istart) begin
          w_state_d = W_DATA;
          w_idx_d   = lcl_iaddr[MEM_AW+OFF_W-1:OFF_W];
          w_cnt_d   = '0;
          w_num_d   = beat_count(lcl_inum);
        end
        if (lcl_den) w_err = 1'b1;
      end
      W_DATA: begin
        if (lcl_istart) w_err = 1'b1;
        if (lcl_den) begin
          ram_we  = 1'b1;
          w_idx_d = w_idx_q + IDX_ONE;
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == w_num_q) w_state_d = W_WAIT;
        end
        // idone together with the final beat is a clean finish; anything earlier is a short burst.
        if (lcl_idone) begin
          w_state_d = W_IDLE;
          if (!(lcl_den && (w_cnt_inc == w_num_q))) w_err = 1'b1;
        end
      end
      W_WAIT: begin
        if (lcl_istart || lcl_den) w_err = 1'b1;
        if (lcl_idone) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel next state: stays in R_DATA with zero beats left for the final dv cycle.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_rem_d   = r_rem_q;
    r_err     = 1'b0;
    ram_re    = 1'b0;
    dv_d      = 1'b0;
    odone_d   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (lcl_ostart) begin
          r_state_d = R_DATA;
          r_idx_d   = lcl_oaddr[MEM_AW+OFF_W-1:OFF_W];
          r_rem_d   = beat_count(lcl_onum);
        end
      end
      R_DATA: begin
        if (lcl_ostart) r_err = 1'b1;
        if (r_rem_q == 9'd0) begin
          r_state_d = R_IDLE;
        end else if (lcl_rden) begin
          ram_re  = 1'b1;
          r_idx_d = r_idx_q + IDX_ONE;
          r_rem_d = r_rem_q - 9'd1;
          dv_d    = 1'b1;
          odone_d = (r_rem_q == 9'd1);
        end
      end
    endcase
  end

  // Write channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_num_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_num_q   <= w_num_d;
    end
  end

  // Read channel state registers and the one-cycle-delayed data strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_rem_q   <= '0;
      dv_q      <= 1'b0;
      odone_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_rem_q   <= r_rem_d;
      dv_q      <= dv_d;
      odone_q   <= odone_d;
    end
  end

  // Sticky protocol error collected from both channels.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | w_err | r_err;
  end

  lcl_burst_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we & ~rst),
    .waddr_i(w_idx_q),
    .wdata_i(lcl_din),
    .re_i   (ram_re & ~rst),
    .raddr_i(r_idx_q),
    .rdata_o(ram_rdata)
  );

  assign lcl_ibusy = (w_state_q != W_IDLE);
  assign lcl_irdy  = (w_state_q == W_DATA);
  assign lcl_obusy = (r_state_q != R_IDLE);
  assign lcl_ordy  = (r_state_q == R_DATA) && (r_rem_q != 9'd0);
  assign lcl_dv    = dv_q;
  assign lcl_odone = odone_q;
  assign lcl_dout  = dv_q ? ram_rdata : '0;
  assign proto_err = err_q;

endmodule

// File: doc/lcl_burst_responder.md
Name: lcl_burst_responder

Overview:
- Target-side model of the local burst interface: services write bursts (lcl_i*) and read bursts (lcl_o*) issued by the memcpy engine, backed by an internal simple dual-port word RAM.
- Serves as the local-memory slave for the memcpy/RSA action datapath and as the bench/loopback target for the engine.
- Write and read channels are independent FSMs and may run concurrently.

Parameters:
ADDR_WIDTH, 64, byte address width on both channels
DATA_WIDTH, 64, beat width; multiple of 8, power of two
MEM_AW, 10, log2 of RAM depth in DATA_WIDTH words

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lcl_istart  in  1  write burst request pulse
lcl_iaddr  in  ADDR_WIDTH  write burst byte start address
lcl_inum  in  8  write beat count (0 = 256)
lcl_ibusy  out  1  write channel busy
lcl_irdy  out  1  ready to accept write beats
lcl_den  in  1  write beat valid
lcl_din  in  DATA_WIDTH  write beat data
lcl_idone  in  1  initiator end-of-write-burst pulse
lcl_ostart  in  1  read burst request pulse
lcl_oaddr  in  ADDR_WIDTH  read burst byte start address
lcl_onum  in  8  read beat count (0 = 256)
lcl_obusy  out  1  read channel busy
lcl_ordy  out  1  ready to serve read beats
lcl_rden  in  1  read beat request
lcl_dv  out  1  read data valid
lcl_dout  out  DATA_WIDTH  read data
lcl_odone  out  1  end-of-read-burst pulse, coincident with last lcl_dv
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=1 at a clk edge): both FSMs go to IDLE, all outputs 0, beat counters 0. RAM contents are not cleared. Reset mid-burst aborts immediately with no odone.
- Word index = byte_addr[MEM_AW+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]. Low byte bits are ignored. The index increments per beat and wraps modulo 2^MEM_AW.
- Beat count N = inum/onum, zero-extended to 9 bits; 0 maps to 256.
- Write FSM W_IDLE -> W_DATA -> W_WAIT -> W_IDLE:
  - W_IDLE: istart=1 latches addr and N, next state W_DATA, ibusy=1 and irdy=1 from the next cycle.
  - W_DATA: each den=1 writes din to RAM[idx] and increments idx and the count. On beat N: irdy<=0, next state W_WAIT.
  - W_WAIT: idone=1 -> W_IDLE, ibusy<=0 the next cycle.
  - idone in W_DATA before N beats: early terminate, -> W_IDLE, proto_err<=1.
  - den outside W_DATA: write dropped, proto_err<=1.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ostart latches addr and N, -> R_DATA, obusy=1 and ordy=1 from the next cycle.
  - R_DATA: each rden=1 with beats remaining issues a RAM read. dv=1 and dout=RAM[idx] exactly 1 cycle later; idx increments.
  - Read of beat N: ordy<=0. Its dv cycle also asserts odone=1 (single cycle). FSM -> R_IDLE, obusy=0 the cycle after odone.
  - rden with no beats remaining (the engine's one-cycle overshoot) is ignored silently; no error.
- Start while the corresponding channel is busy: ignored, proto_err<=1. istart and ostart in the same cycle are both accepted.
- Same-cycle write and read of the same RAM word: read returns old data (read-first).
- rden/den gaps are allowed at any point; no timeout.
- proto_err clears only on rst.

Decomposition:
- Package lcl_burst_pkg: write/read state enums, BEAT_CNT_W=9, a function mapping 8-bit num to beat count (0->256).
- Sub-module lcl_burst_ram: simple dual-port RAM, 1-cycle registered read, read-first, parameters DATA_WIDTH and MEM_AW.

Test Plan:
- Write burst iaddr=0x100, inum=4, din 0xA0..0xA3, then idone -> RAM words 0x20..0x23 hold 0xA0..0xA3; ibusy falls 1 cycle after idone; proto_err=0.
- Read burst oaddr=0x100, onum=4, rden held 5 cycles -> dv for 4 cycles carrying 0xA0..0xA3, each 1 cycle after rden; odone with the 4th dv; 5th rden ignored; obusy falls next cycle.
- Wrap: MEM_AW=4, write iaddr=0x70 (word 14), inum=4 -> words 14, 15, 0, 1 written; read-back matches.
- inum=0 -> 256 beats accepted before irdy drops; idone after beat 200 -> early terminate, proto_err=1.
- Concurrent write and read of word 5 in the same cycle -> dout = old value; next read gets the new value. istart during W_DATA -> ignored, proto_err=1.
- rst asserted mid-read after 2 of 8 beats -> next cycle dv=0, odone never pulses, obusy=0; a fresh burst completes normally.
